// File: rtl/universal_reg_n.sv
// rtl/universal_reg_n.sv - N-bit universal register: hold, load, shift, rotate, up/down count
module universal_reg_n #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_carry;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic             w_carry_nxt;

  // Next-state selection; en=0 and HOLD keep every state bit as is
  always_comb begin
    w_q_nxt     = r_q;
    w_sout_nxt  = r_sout;
    w_carry_nxt = r_carry;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_q_nxt     = r_q;
        end
        MODE_LOAD: begin
          w_q_nxt     = d;
          w_sout_nxt  = 1'b0;
          w_carry_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt     = {r_q[WIDTH-2:0], sin};
          w_sout_nxt  = r_q[WIDTH-1];
          w_carry_nxt = 1'b0;
        end
        MODE_SHR: begin
          w_q_nxt     = {sin, r_q[WIDTH-1:1]};
          w_sout_nxt  = r_q[0];
          w_carry_nxt = 1'b0;
        end
        MODE_ROTL: begin
          w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_nxt  = r_q[WIDTH-1];
          w_carry_nxt = 1'b0;
        end
        MODE_ROTR: begin
          w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_nxt  = r_q[0];
          w_carry_nxt = 1'b0;
        end
        MODE_INC: begin
          w_q_nxt     = r_q + ONE;
          w_sout_nxt  = 1'b0;
          w_carry_nxt = (r_q == ALL_ONES);
        end
        MODE_DEC: begin
          w_q_nxt     = r_q - ONE;
          w_sout_nxt  = 1'b0;
          w_carry_nxt = (r_q == '0);
        end
        default: begin
          w_q_nxt     = r_q;
        end
      endcase
    end
  end

  // State flops with asynchronous reset; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= RESET_VALUE;
      r_sout  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_sout  <= w_sout_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign q     = r_q;
  assign sout  = r_sout;
  assign carry = r_carry;
  assign zero  = (r_q == '0);

endmodule

// File: tb/tb_universal_reg_n.sv
// tb/tb_universal_reg_n.sv - directed self-checking bench for universal_reg_n
module tb_universal_reg_n;

  localparam int         W    = 8;
  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] SHR  = 3'b011;
  localparam logic [2:0] ROTL = 3'b100;
  localparam logic [2:0] ROTR = 3'b101;
  localparam logic [2:0] INC  = 3'b110;
  localparam logic [2:0] DEC  = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] d = '0;
  logic         sin = 1'b0;
  logic [W-1:0] q;
  logic         sout;
  logic         carry;
  logic         zero;

  int checks = 0;
  int failures = 0;

  universal_reg_n #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .carry (carry),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic s);
    @(negedge clk);
    en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: async reset while clk low
    #2 rst = 1'b1;
    #1;
    chk("rst_q", q, 8'hA5);
    chk("rst_sout", {7'b0, sout}, 8'h00);
    chk("rst_carry", {7'b0, carry}, 8'h00);
    chk("rst_zero", {7'b0, zero}, 8'h00);
    step(1'b1, LOAD, 8'h00, 1'b0);
    chk("rst_hold_edge_q", q, 8'hA5);
    @(negedge clk);
    rst = 1'b0;

    // 2: load, shift left, shift right
    step(1'b1, LOAD, 8'h81, 1'b0);
    chk("load81_q", q, 8'h81);
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("shl_q", q, 8'h02);
    chk("shl_sout", {7'b0, sout}, 8'h01);
    step(1'b1, SHR, 8'h00, 1'b1);
    chk("shr_q", q, 8'h81);
    chk("shr_sout", {7'b0, sout}, 8'h00);

    // 3: rotates
    step(1'b1, LOAD, 8'h80, 1'b0);
    step(1'b1, ROTL, 8'h00, 1'b0);
    chk("rotl_q", q, 8'h01);
    chk("rotl_sout", {7'b0, sout}, 8'h01);
    step(1'b1, ROTR, 8'h00, 1'b0);
    chk("rotr_q", q, 8'h80);
    chk("rotr_sout", {7'b0, sout}, 8'h01);
    for (int i = 0; i < 8; i++) step(1'b1, ROTL, 8'h00, 1'b0);
    chk("rotl8_q", q, 8'h80);
    chk("rotl8_sout", {7'b0, sout}, 8'h00);

    // shift of all-ones / all-zeros
    step(1'b1, LOAD, 8'hFF, 1'b0);
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("shl_ones_q", q, 8'hFE);
    chk("shl_ones_sout", {7'b0, sout}, 8'h01);
    step(1'b1, LOAD, 8'h00, 1'b0);
    chk("load0_zero", {7'b0, zero}, 8'h01);
    step(1'b1, SHR, 8'h00, 1'b0);
    chk("shr_zeros_q", q, 8'h00);
    chk("shr_zeros_sout", {7'b0, sout}, 8'h00);

    // 4: count with wrap
    step(1'b1, LOAD, 8'hFE, 1'b0);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("inc1_q", q, 8'hFF);
    chk("inc1_carry", {7'b0, carry}, 8'h00);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("inc2_q", q, 8'h00);
    chk("inc2_carry", {7'b0, carry}, 8'h01);
    chk("inc2_zero", {7'b0, zero}, 8'h01);
    step(1'b1, HOLD, 8'h00, 1'b0);
    chk("hold_carry", {7'b0, carry}, 8'h01);
    step(1'b1, DEC, 8'h00, 1'b0);
    chk("dec_q", q, 8'hFF);
    chk("dec_carry", {7'b0, carry}, 8'h01);
    chk("dec_zero", {7'b0, zero}, 8'h00);
    step(1'b1, DEC, 8'h00, 1'b0);
    chk("dec2_q", q, 8'hFE);
    chk("dec2_carry", {7'b0, carry}, 8'h00);
    step(1'b1, DEC, 8'h00, 1'b0);
    step(1'b1, LOAD, 8'h00, 1'b0);
    chk("load_clr_carry", {7'b0, carry}, 8'h00);

    // 5: en=0 holds under every mode
    step(1'b1, LOAD, 8'h9E, 1'b0);
    step(1'b1, SHL, 8'h00, 1'b0);
    chk("pre_hold_q", q, 8'h3C);
    chk("pre_hold_sout", {7'b0, sout}, 8'h01);
    for (int m = 0; m < 8; m++) begin
      step(1'b0, 3'(m), 8'hFF, 1'b1);
      chk($sformatf("en0_m%0d_q", m), q, 8'h3C);
      chk($sformatf("en0_m%0d_sout", m), {7'b0, sout}, 8'h01);
      chk($sformatf("en0_m%0d_carry", m), {7'b0, carry}, 8'h00);
    end

    // 6: reset mid-count
    step(1'b1, LOAD, 8'hFF, 1'b0);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("wrap_carry", {7'b0, carry}, 8'h01);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("cnt1_q", q, 8'h01);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("cnt2_q", q, 8'h02);
    step(1'b1, INC, 8'h00, 1'b0);
    chk("cnt3_q", q, 8'h03);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", q, 8'hA5);
    chk("midrst_carry", {7'b0, carry}, 8'h00);
    @(posedge clk);
    #1;
    chk("midrst_edge_q", q, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_inc_q", q, 8'hA6);
    chk("post_rst_carry", {7'b0, carry}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
